// File: rtl/inst_rom_arbiter.sv
// Arbitrates the single combinational instruction ROM between the IF fetch port and a debug read port.
// IF has fixed priority, but a debug request that keeps losing is forced through after MAX_WAIT cycles.
module inst_rom_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_err,

    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_data,
    output logic              dbg_err,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,

    output logic              stallreq
);

    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              if_err_q, if_err_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic              dbg_err_q, dbg_err_d;
    logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

    logic force_dbg;
    logic if_aligned;
    logic dbg_aligned;

    // Arbitration and ROM drive; every request-side output is held low while in reset.
    always_comb begin
        if_aligned  = (if_addr[1:0] == 2'b00);
        dbg_aligned = (dbg_addr[1:0] == 2'b00);
        force_dbg   = dbg_req && (wait_cnt_q == WAIT_MAX);
        dbg_gnt     = !rst && dbg_req && (!if_req || force_dbg);
        if_gnt      = !rst && if_req && !dbg_gnt;
        stallreq    = !rst && if_req && !if_gnt;

        rom_ce   = 1'b0;
        rom_addr = '0;
        if (if_gnt) begin
            rom_ce   = if_aligned;
            rom_addr = if_addr;
        end else if (dbg_gnt) begin
            rom_ce   = dbg_aligned;
            rom_addr = dbg_addr;
        end
    end

    // Starvation counter: counts consecutive lost cycles, clears on grant or withdrawal.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dbg_req || dbg_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // Return path: a misaligned grant returns a zero word flagged with err.
    always_comb begin
        if_rvalid_d  = if_gnt;
        if_err_d     = if_gnt && !if_aligned;
        if_inst_d    = if_inst_q;
        dbg_rvalid_d = dbg_gnt;
        dbg_err_d    = dbg_gnt && !dbg_aligned;
        dbg_data_d   = dbg_data_q;
        if (if_gnt) begin
            if_inst_d = if_aligned ? rom_inst : '0;
        end
        if (dbg_gnt) begin
            dbg_data_d = dbg_aligned ? rom_inst : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q   <= '0;
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            if_inst_q    <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
            dbg_data_q   <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_err_q     <= if_err_d;
            if_inst_q    <= if_inst_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_err_q    <= dbg_err_d;
            dbg_data_q   <= dbg_data_d;
        end
    end

    // Gating by rst kills a return that was granted just before reset asserted.
    always_comb begin
        if_rvalid  = if_rvalid_q && !rst;
        if_err     = if_err_q && !rst;
        if_inst    = rst ? '0 : if_inst_q;
        dbg_rvalid = dbg_rvalid_q && !rst;
        dbg_err    = dbg_err_q && !rst;
        dbg_data   = rst ? '0 : dbg_data_q;
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Directed bench for inst_rom_arbiter: stimulus pushes expected returns, a negedge monitor pops and checks them.
module tb_inst_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dbg_req;
    logic [31:0] if_addr, dbg_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_inst;
    logic        dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_data;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic        stallreq;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dbg_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_dbg = '0;

    inst_rom_arbiter #(.MAX_WAIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_inst(if_inst), .if_err(if_err),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_data(dbg_data), .dbg_err(dbg_err),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        case (a)
            32'h0000_0008: return 32'h3401_1100;
            32'h0000_0010: return 32'h0000_000F;
            default:       return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    always_comb rom_inst = rom_fn(rom_addr);

    // One bus cycle: drive at posedge+1, check combinational outputs at posedge+4.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                        input logic r, input logic e_ig, input logic e_dg, input logic e_ce,
                        input logic e_st, input string nm);
        logic [31:0] e_addr;
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da; rst = r;
        if (r) begin
            if (if_q.size() > 0 && if_q[if_q.size()-1].due == cyc) if_q.delete(if_q.size()-1);
            if (dbg_q.size() > 0 && dbg_q[dbg_q.size()-1].due == cyc) dbg_q.delete(dbg_q.size()-1);
        end
        #3;
        e_addr = e_ig ? ia : (e_dg ? da : 32'h0);
        n_checks++;
        if (if_gnt !== e_ig || dbg_gnt !== e_dg || rom_ce !== e_ce || stallreq !== e_st || rom_addr !== e_addr) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got ig=%b dg=%b ce=%b st=%b addr=%h, expected ig=%b dg=%b ce=%b st=%b addr=%h",
                     nm, cyc, if_gnt, dbg_gnt, rom_ce, stallreq, rom_addr, e_ig, e_dg, e_ce, e_st, e_addr);
        end
        if (e_ig) if_q.push_back('{(ia[1:0] != 2'b00) ? 32'h0 : rom_fn(ia), ia[1:0] != 2'b00, cyc + 1});
        if (e_dg) dbg_q.push_back('{(da[1:0] != 2'b00) ? 32'h0 : rom_fn(da), da[1:0] != 2'b00, cyc + 1});
    endtask

    task automatic idle(input string nm);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    // Return-path monitor: due entries must appear, otherwise rvalid/err low and data held.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            last_if  = '0;
            last_dbg = '0;
        end
        n_checks++;
        if (if_q.size() > 0 && if_q[0].due <= cyc) begin
            e = if_q.pop_front();
            if (if_rvalid !== 1'b1 || if_inst !== e.data || if_err !== e.err) begin
                n_fail++;
                $display("FAIL if_return cyc%0d: got rv=%b inst=%h err=%b, expected rv=1 inst=%h err=%b",
                         cyc, if_rvalid, if_inst, if_err, e.data, e.err);
            end
            last_if = e.data;
        end else if (if_rvalid !== 1'b0 || if_err !== 1'b0 || if_inst !== last_if) begin
            n_fail++;
            $display("FAIL if_idle cyc%0d: got rv=%b err=%b inst=%h, expected rv=0 err=0 inst=%h",
                     cyc, if_rvalid, if_err, if_inst, last_if);
        end
        n_checks++;
        if (dbg_q.size() > 0 && dbg_q[0].due <= cyc) begin
            e = dbg_q.pop_front();
            if (dbg_rvalid !== 1'b1 || dbg_data !== e.data || dbg_err !== e.err) begin
                n_fail++;
                $display("FAIL dbg_return cyc%0d: got rv=%b data=%h err=%b, expected rv=1 data=%h err=%b",
                         cyc, dbg_rvalid, dbg_data, dbg_err, e.data, e.err);
            end
            last_dbg = e.data;
        end else if (dbg_rvalid !== 1'b0 || dbg_err !== 1'b0 || dbg_data !== last_dbg) begin
            n_fail++;
            $display("FAIL dbg_idle cyc%0d: got rv=%b err=%b data=%h, expected rv=0 err=0 data=%h",
                     cyc, dbg_rvalid, dbg_err, dbg_data, last_dbg);
        end
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; if_addr = '0; dbg_addr = '0;

        // T1: reset with both requests held
        step(1, 32'h8, 1, 32'h10, 1, 0, 0, 0, 0, "t1_reset0");
        step(1, 32'h8, 1, 32'h10, 1, 0, 0, 0, 0, "t1_reset1");
        idle("t1_idle");

        // T2: IF only
        step(1, 32'h8, 0, 32'h0, 0, 1, 0, 1, 0, "t2_if_gnt");
        idle("t2_ret");

        // T3: debug only
        step(0, 32'h0, 1, 32'h10, 0, 0, 1, 1, 0, "t3_dbg_gnt");
        idle("t3_ret");

        // T4: contention; debug forced through every fifth cycle
        for (int i = 0; i < 15; i++) begin
            step(1, 32'h100 + 32'(4 * i), 1, 32'h200, 0,
                 (i % 5) != 4, (i % 5) == 4, 1, (i % 5) == 4, "t4_contend");
        end
        idle("t4_ret");

        // T5: misaligned accesses on both ports
        step(0, 32'h0, 1, 32'h6, 0, 0, 1, 0, 0, "t5_dbg_misal");
        step(1, 32'h2, 0, 32'h0, 0, 1, 0, 0, 0, "t5_if_misal");
        idle("t5_ret");

        // Debug withdrawal clears the starvation count
        step(1, 32'h20, 1, 32'h30, 0, 1, 0, 1, 0, "drop_lose0");
        step(1, 32'h20, 1, 32'h30, 0, 1, 0, 1, 0, "drop_lose1");
        step(1, 32'h24, 0, 32'h0, 0, 1, 0, 1, 0, "drop_withdraw");
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h28 + 32'(4 * i), 1, 32'h34, 0, 1, 0, 1, 0, "drop_relose");
        end
        step(1, 32'h40, 1, 32'h34, 0, 0, 1, 1, 1, "drop_forced");
        step(1, 32'h40, 0, 32'h0, 0, 1, 0, 1, 0, "drop_if_after");
        idle("drop_ret");

        // T6: reset right after an IF grant kills its return
        step(1, 32'h8, 0, 32'h0, 0, 1, 0, 1, 0, "t6_if_gnt");
        step(1, 32'h8, 0, 32'h0, 1, 0, 0, 0, 0, "t6_reset");
        step(1, 32'h8, 0, 32'h0, 0, 1, 0, 1, 0, "t6_refetch");
        idle("t6_ret");
        idle("t6_tail");

        n_checks++;
        if (if_q.size() != 0 || dbg_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d outstanding, expected 0/0", if_q.size(), dbg_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
